div_req_arbiter: RTL and testbench

//  Round-robin scheduler sharing one sequential divider engine among N_REQ requesters.

---
 rtl/div_req_arbiter_if.sv | 35 +++
 rtl/div_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_div_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_req_arbiter_if.sv
// Bundle between the requesters/divider engine and the round-robin divider arbiter.
// The arbiter takes the slave view; requesters and engine together take the master view.
interface div_req_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W     = 7
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] dividend;
    logic [N_REQ*W-1:0] divisor;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [W-1:0]       quotient;
    logic [W-1:0]       remainder;
    logic               err;
    logic               busy;
    logic               div_start;
    logic               div_abort;
    logic [W-1:0]       div_dividend;
    logic [W-1:0]       div_divisor;
    logic               div_done;
    logic [W-1:0]       div_quotient;
    logic [W-1:0]       div_remainder;

    modport master (
        output req, dividend, divisor, div_done, div_quotient, div_remainder,
        input  gnt, rsp_valid, quotient, remainder, err, busy,
               div_start, div_abort, div_dividend, div_divisor
    );

    modport slave (
        input  req, dividend, divisor, div_done, div_quotient, div_remainder,
        output gnt, rsp_valid, quotient, remainder, err, busy,
               div_start, div_abort, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_req_arbiter.sv
// Round-robin scheduler sharing one sequential divider among N_REQ requesters.
// Divide-by-zero and engine timeout are answered locally without the engine.
module div_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 7,
    parameter int TIMEOUT = 256
) (
    input logic             clk,
    input logic             rst,
    div_req_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        LAUNCH = 4'b0010,
        WAIT   = 4'b0100,
        RESP   = 4'b1000
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    ptr_reg;
    logic [PW-1:0]    sel_reg;
    logic [W-1:0]     dividend_reg;
    logic [W-1:0]     divisor_reg;
    logic             dz_reg;
    logic [TW-1:0]    timer_reg;
    logic [W-1:0]     quotient_reg;
    logic [W-1:0]     remainder_reg;
    logic             err_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [N_REQ-1:0] rsp_valid_reg;
    logic             start_reg;
    logic             abort_reg;

    logic [W-1:0]     dividend_sl [N_REQ];
    logic [W-1:0]     divisor_sl  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign dividend_sl[gi] = bus.dividend[gi*W +: W];
            assign divisor_sl[gi]  = bus.divisor[gi*W +: W];
        end
    endgenerate

    // Scan ptr, ptr+1, ... (mod N_REQ); the lowest rotated offset with a request wins.
    logic [PW:0]   scan_sum;
    logic [PW-1:0] scan_idx;
    logic          pick_valid;
    logic [PW-1:0] pick_next;

    always_comb begin
        scan_sum   = '0;
        scan_idx   = '0;
        pick_valid = 1'b0;
        pick_next  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan_sum = {1'b0, ptr_reg} + (PW+1)'(i);
            if (scan_sum >= (PW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PW+1)'(N_REQ);
            end
            scan_idx = scan_sum[PW-1:0];
            if (bus.req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_next  = scan_idx;
            end
        end
    end

    logic [PW-1:0] ptr_next;
    assign ptr_next = (sel_reg == PW'(N_REQ - 1)) ? '0 : sel_reg + 1'b1;

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] k);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            sel_reg       <= '0;
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            dz_reg        <= 1'b0;
            timer_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            err_reg       <= 1'b0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            start_reg     <= 1'b0;
            abort_reg     <= 1'b0;
        end else begin
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            start_reg     <= 1'b0;
            abort_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        sel_reg      <= pick_next;
                        dividend_reg <= dividend_sl[pick_next];
                        divisor_reg  <= divisor_sl[pick_next];
                        dz_reg       <= (divisor_sl[pick_next] == '0);
                        // Grant and launch are registered here so they appear during LAUNCH.
                        gnt_reg      <= onehot(pick_next);
                        start_reg    <= (divisor_sl[pick_next] != '0);
                        state_reg    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (dz_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= dividend_reg;
                        err_reg       <= 1'b1;
                        rsp_valid_reg <= onehot(sel_reg);
                        state_reg     <= RESP;
                    end else begin
                        timer_reg <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.div_done) begin
                        quotient_reg  <= bus.div_quotient;
                        remainder_reg <= bus.div_remainder;
                        err_reg       <= 1'b0;
                        rsp_valid_reg <= onehot(sel_reg);
                        state_reg     <= RESP;
                    end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                        abort_reg     <= 1'b1;
                        quotient_reg  <= '1;
                        remainder_reg <= '0;
                        err_reg       <= 1'b1;
                        rsp_valid_reg <= onehot(sel_reg);
                        state_reg     <= RESP;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RESP: begin
                    ptr_reg   <= ptr_next;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.quotient     = quotient_reg;
    assign bus.remainder    = remainder_reg;
    assign bus.err          = err_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.div_start    = start_reg;
    assign bus.div_abort    = abort_reg;
    assign bus.div_dividend = dividend_reg;
    assign bus.div_divisor  = divisor_reg;
endmodule

// File: tb/tb_div_req_arbiter.sv
// Scoreboard bench for div_req_arbiter: stimulus queues expected grants/responses,
// a monitor pops and compares them whenever the arbiter presents gnt or rsp_valid.
module tb_div_req_arbiter;
    localparam int N  = 4;
    localparam int W  = 7;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_req_arbiter_if #(.N_REQ(N), .W(W)) bus ();

    div_req_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int           k;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         err;
    } rsp_t;

    rsp_t exp_rsp[$];
    int   exp_gnt[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   engine_on = 1'b1;
    int   eng_lat   = 4;
    int   stray_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rsp(input int k, input int q, input int r, input int e);
        rsp_t x;
        x.k   = k;
        x.q   = W'(q);
        x.r   = W'(r);
        x.err = e[0];
        exp_rsp.push_back(x);
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        bus.dividend[k*W +: W] = W'(a);
        bus.divisor[k*W +: W]  = W'(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("gnt_seen", 32'(bus.gnt != '0), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        check("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic hold_reqs(input logic [N-1:0] mask, input int n);
        int cnt;
        cnt = 0;
        bus.req = mask;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                cnt++;
                if (cnt == n) break;
            end
        end
        bus.req = '0;
        check("grant_count", 32'(cnt), 32'(n));
        wait_idle();
    endtask

    // Divider engine model plus injected stray done pulses.
    initial begin
        int           served = 0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bus.div_done      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        forever begin
            @(negedge clk);
            if (stray_req != served) begin
                served++;
                bus.div_done      = 1'b1;
                bus.div_quotient  = 7'd5;
                bus.div_remainder = 7'd5;
                @(negedge clk);
                bus.div_done = 1'b0;
            end else if (engine_on && bus.div_start === 1'b1) begin
                a = bus.div_dividend;
                b = bus.div_divisor;
                repeat (eng_lat) @(negedge clk);
                bus.div_done      = 1'b1;
                bus.div_quotient  = a / b;
                bus.div_remainder = a % b;
                @(negedge clk);
                bus.div_done = 1'b0;
            end
        end
    end

    // Monitor: every grant and every response is popped against the scoreboard.
    initial begin
        rsp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus.gnt != '0) begin
                    check("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
                    if (exp_gnt.size() == 0) begin
                        check("gnt_unexpected", 32'(bus.gnt), 32'd0);
                    end else begin
                        k = exp_gnt.pop_front();
                        check("gnt_index", 32'(bus.gnt), 32'(1 << k));
                        $display("grant: requester %0d gnt=%b", k, bus.gnt);
                    end
                end
                if (bus.rsp_valid != '0) begin
                    if (exp_rsp.size() == 0) begin
                        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                    end else begin
                        e = exp_rsp.pop_front();
                        check("rsp_index", 32'(bus.rsp_valid), 32'(1 << e.k));
                        check("rsp_quotient", 32'(bus.quotient), 32'(e.q));
                        check("rsp_remainder", 32'(bus.remainder), 32'(e.r));
                        check("rsp_err", 32'(bus.err), 32'(e.err));
                        $display("response: requester %0d q=%0h r=%0h err=%0b",
                                 e.k, bus.quotient, bus.remainder, bus.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst          = 1'b1;
        bus.req      = '0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_result", 32'({bus.quotient, bus.remainder, bus.err}), 32'd0);
        check("reset_engine_ctl", 32'({bus.div_start, bus.div_abort}), 32'd0);
        check("reset_operands", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);

        // All four requesting from ptr 0: strict rotation, then back to 0.
        set_ops(0, 17, 5);
        set_ops(1, 100, 7);
        set_ops(2, 50, 8);
        set_ops(3, 127, 10);
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
        exp_gnt.push_back(3); exp_gnt.push_back(0);
        push_rsp(0, 3, 2, 0);
        push_rsp(1, 14, 2, 0);
        push_rsp(2, 6, 2, 0);
        push_rsp(3, 12, 7, 0);
        push_rsp(0, 3, 2, 0);
        hold_reqs(4'b1111, 5);

        // Single request 17/5 through the engine.
        exp_gnt.push_back(0);
        push_rsp(0, 3, 2, 0);
        bus.req = 4'b0001;
        wait_gnt(got);
        if (got) begin
            check("t1_start_with_gnt", 32'(bus.div_start), 32'd1);
            check("t1_div_dividend", 32'(bus.div_dividend), 32'd17);
            check("t1_div_divisor", 32'(bus.div_divisor), 32'd5);
        end
        bus.req = '0;
        wait_idle();

        // Divide by zero answered locally one cycle after the grant.
        set_ops(2, 9, 0);
        exp_gnt.push_back(2);
        push_rsp(2, 7'h7F, 9, 1);
        bus.req = 4'b0100;
        wait_gnt(got);
        check("t3_no_start", 32'(bus.div_start), 32'd0);
        bus.req = '0;
        tick(1);
        check("t3_rsp_next_cycle", 32'(bus.rsp_valid), 32'b0100);
        check("t3_no_start_rsp", 32'(bus.div_start), 32'd0);
        wait_idle();

        // Silent engine: abort exactly TO cycles after entering WAIT.
        engine_on = 1'b0;
        set_ops(1, 50, 7);
        exp_gnt.push_back(1);
        push_rsp(1, 7'h7F, 0, 1);
        bus.req = 4'b0010;
        wait_gnt(got);
        bus.req = '0;
        tick(TO);
        check("t4_abort_not_early", 32'(bus.div_abort), 32'd0);
        tick(1);
        check("t4_abort_pulse", 32'(bus.div_abort), 32'd1);
        check("t4_rsp_with_abort", 32'(bus.rsp_valid), 32'b0010);
        wait_idle();
        stray_req++;
        tick(3);
        check("t4_late_done_busy", 32'(bus.busy), 32'd0);
        check("t4_result_held", 32'(bus.quotient), 32'h7F);
        engine_on = 1'b1;

        // Reset while the engine is working; its late result must vanish.
        set_ops(0, 30, 4);
        eng_lat = 6;
        exp_gnt.push_back(0);
        bus.req = 4'b0001;
        wait_gnt(got);
        bus.req = '0;
        tick(2);
        check("t5_busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_result", 32'({bus.quotient, bus.remainder, bus.err}), 32'd0);
        check("t5_rst_operands", 32'({bus.div_dividend, bus.div_divisor}), 32'd0);
        check("t5_rst_pulses", 32'({bus.gnt, bus.rsp_valid, bus.div_start, bus.div_abort}), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(10);
        eng_lat = 4;

        // After reset ptr=0 so 1 wins over 3; then ptr=2 puts 3 ahead of 1.
        set_ops(1, 100, 7);
        exp_gnt.push_back(1); exp_gnt.push_back(3);
        exp_gnt.push_back(1); exp_gnt.push_back(3);
        push_rsp(1, 14, 2, 0);
        push_rsp(3, 12, 7, 0);
        push_rsp(1, 14, 2, 0);
        push_rsp(3, 12, 7, 0);
        hold_reqs(4'b1010, 4);

        tick(2);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
